passenger_request_queue: RTL and testbench

- Sits directly upstream of the bus-route controller.
- Turns PS/2 keyboard make/break events from KeyboardDecoder into per-stop waiting-passenger queues.
- Exports those queues as the 2-bit thermometer words (at_b1, at_b2) that the controller boards from and shows on LED.
- Accepts board pulses back from the controller, which empty a stop's queue once its passengers are collected.

---
 rtl/passenger_request_queue_pkg.sv | 26 ++
 rtl/passenger_request_queue_stop_queue.sv | 69 ++++++
 rtl/passenger_request_queue.sv | 80 ++++++++
 tb/tb_passenger_request_queue.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/passenger_request_queue_pkg.sv
// Shared definitions for the passenger request queue and the bus-route controller:
// keypad scan codes and the thermometer queue encoding.
package passenger_request_queue_pkg;

  localparam logic [8:0] SC_KP1 = 9'h069;
  localparam logic [8:0] SC_KP2 = 9'h072;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'b00,
    Q_ONE   = 2'b10,
    Q_TWO   = 2'b11
  } queue_e;

  // Occupancy of a thermometer word is simply its number of set bits.
  function automatic int unsigned q_occupancy(input queue_e q);
    return int'($countones(q));
  endfunction

  function automatic queue_e q_push(input queue_e q);
    case (q)
      Q_EMPTY: return Q_ONE;
      default: return Q_TWO;
    endcase
  endfunction

endpackage

// File: rtl/passenger_request_queue_stop_queue.sv
// One stop's waiting-passenger queue: make/break arming, board edge detect,
// thermometer occupancy and the accept pulse; reject_o is the unregistered drop strobe.
module stop_queue
  import passenger_request_queue_pkg::*;
#(
  parameter int unsigned QCAP = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       make_i,
  input  logic       break_i,
  input  logic       board_i,
  output logic [1:0] queue_o,
  output logic       add_o,
  output logic       reject_o
);

  queue_e queue_q, queue_d;
  queue_e base;
  logic   armed_q, armed_d;
  logic   board_q;
  logic   add_q, add_d;
  logic   board_edge;
  logic   press;

  always_comb begin
    board_edge = board_i & ~board_q;
    press      = make_i & armed_q;
    // A board edge empties the stop before any same-cycle press is queued.
    base       = board_edge ? Q_EMPTY : queue_q;

    armed_d = armed_q;
    if (press) begin
      armed_d = 1'b0;
    end else if (break_i) begin
      armed_d = 1'b1;
    end

    queue_d  = base;
    add_d    = 1'b0;
    reject_o = 1'b0;
    if (press) begin
      if (q_occupancy(base) >= QCAP) begin
        reject_o = 1'b1;
      end else begin
        queue_d = q_push(base);
        add_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      queue_q <= Q_EMPTY;
      armed_q <= 1'b1;
      board_q <= 1'b0;
      add_q   <= 1'b0;
    end else begin
      queue_q <= queue_d;
      armed_q <= armed_d;
      board_q <= board_i;
      add_q   <= add_d;
    end
  end

  assign queue_o = queue_q;
  assign add_o   = add_q;

endmodule

// File: rtl/passenger_request_queue.sv
// Turns keypad make/break events into per-stop passenger queues for the bus-route
// controller, with a registered drop pulse and saturating rejected-press counter.
module passenger_request_queue
  import passenger_request_queue_pkg::*;
#(
  parameter logic [8:0]  KEY_B1 = SC_KP1,
  parameter logic [8:0]  KEY_B2 = SC_KP2,
  parameter int unsigned QCAP   = 2,
  parameter int unsigned DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [511:0]      key_down,
  input  logic [8:0]        last_change,
  input  logic              key_valid,
  input  logic              board_b1,
  input  logic              board_b2,
  output logic [1:0]        at_b1,
  output logic [1:0]        at_b2,
  output logic              add_b1,
  output logic              add_b2,
  output logic              drop,
  output logic [DROP_W-1:0] drop_cnt
);

  logic              level;
  logic              hit_b1, hit_b2;
  logic              rej_b1, rej_b2;
  logic              drop_d, drop_q;
  logic [DROP_W-1:0] cnt_d, cnt_q;

  // The pressed level of the event's own code; equals key_down[KEY_BN] on a hit.
  assign level  = key_down[last_change];
  assign hit_b1 = key_valid && (last_change == KEY_B1);
  assign hit_b2 = key_valid && (last_change == KEY_B2);

  stop_queue #(.QCAP(QCAP)) u_b1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .make_i  (hit_b1 & level),
    .break_i (hit_b1 & ~level),
    .board_i (board_b1),
    .queue_o (at_b1),
    .add_o   (add_b1),
    .reject_o(rej_b1)
  );

  stop_queue #(.QCAP(QCAP)) u_b2 (
    .clk_i   (clk),
    .rst_i   (rst),
    .make_i  (hit_b2 & level),
    .break_i (hit_b2 & ~level),
    .board_i (board_b2),
    .queue_o (at_b2),
    .add_o   (add_b2),
    .reject_o(rej_b2)
  );

  always_comb begin
    drop_d = rej_b1 | rej_b2;
    cnt_d  = cnt_q;
    if (drop_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
    end
  end

  assign drop     = drop_q;
  assign drop_cnt = cnt_q;

endmodule

// File: tb/tb_passenger_request_queue.sv
// Directed bench for passenger_request_queue: a vector table for the single-cycle
// behaviour plus hand sequences for drop saturation and asynchronous reset.
module tb_passenger_request_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic         board_b1, board_b2;
  logic [1:0]   at_b1, at_b2;
  logic         add_b1, add_b2, drop;
  logic [7:0]   drop_cnt;

  int total = 0;
  int bad   = 0;

  passenger_request_queue #(
    .KEY_B1(9'h069),
    .KEY_B2(9'h072),
    .QCAP  (2),
    .DROP_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_down   (key_down),
    .last_change(last_change),
    .key_valid  (key_valid),
    .board_b1   (board_b1),
    .board_b2   (board_b2),
    .at_b1      (at_b1),
    .at_b2      (at_b2),
    .add_b1     (add_b1),
    .add_b2     (add_b2),
    .drop       (drop),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       kv;
    logic [8:0] code;
    logic       down;
    logic       b1;
    logic       b2;
    logic [1:0] at1;
    logic [1:0] at2;
    logic       a1;
    logic       a2;
    logic       dr;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic kv, logic [8:0] code, logic down, logic b1, logic b2,
                              logic [1:0] at1, logic [1:0] at2, logic a1, logic a2,
                              logic dr, logic [7:0] cnt);
    vec_t v;
    v.kv = kv; v.code = code; v.down = down; v.b1 = b1; v.b2 = b2;
    v.at1 = at1; v.at2 = at2; v.a1 = a1; v.a2 = a2; v.dr = dr; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic kv, input logic [8:0] code, input logic down,
                       input logic b1, input logic b2);
    key_valid   = kv;
    last_change = code;
    key_down    = '0;
    key_down[code] = down;
    board_b1    = b1;
    board_b2    = b2;
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic kv, input logic [8:0] code, input logic down,
                      input logic b1, input logic b2);
    drive(kv, code, down, b1, b2);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] at1, input logic [1:0] at2,
                         input logic a1, input logic a2, input logic dr, input logic [7:0] cnt);
    chk({tag, ".at_b1"},    32'(at_b1),    32'(at1));
    chk({tag, ".at_b2"},    32'(at_b2),    32'(at2));
    chk({tag, ".add_b1"},   32'(add_b1),   32'(a1));
    chk({tag, ".add_b2"},   32'(add_b2),   32'(a2));
    chk({tag, ".drop"},     32'(drop),     32'(dr));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(cnt));
  endtask

  initial begin
    logic [7:0] exp_cnt;

    //                kv  code    dn b1 b2   at1    at2    a1 a2 dr cnt
    vecs.push_back(mk(1, 9'h069, 1, 0, 0, 2'b10, 2'b00, 1, 0, 0, 8'd0)); // first B1 passenger
    vecs.push_back(mk(0, 9'h000, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 8'd0)); // add is one cycle
    vecs.push_back(mk(1, 9'h072, 1, 0, 0, 2'b10, 2'b10, 0, 1, 0, 8'd0)); // B2 make
    vecs.push_back(mk(1, 9'h072, 1, 0, 0, 2'b10, 2'b10, 0, 0, 0, 8'd0)); // typematic
    vecs.push_back(mk(1, 9'h072, 1, 0, 0, 2'b10, 2'b10, 0, 0, 0, 8'd0)); // typematic
    vecs.push_back(mk(1, 9'h072, 0, 0, 0, 2'b10, 2'b10, 0, 0, 0, 8'd0)); // B2 break
    vecs.push_back(mk(1, 9'h072, 1, 0, 0, 2'b10, 2'b11, 0, 1, 0, 8'd0)); // B2 second
    vecs.push_back(mk(1, 9'h069, 0, 0, 0, 2'b10, 2'b11, 0, 0, 0, 8'd0)); // B1 break
    vecs.push_back(mk(1, 9'h069, 1, 0, 0, 2'b11, 2'b11, 1, 0, 0, 8'd0)); // B1 second
    vecs.push_back(mk(1, 9'h069, 0, 0, 0, 2'b11, 2'b11, 0, 0, 0, 8'd0)); // B1 break
    vecs.push_back(mk(1, 9'h069, 1, 0, 0, 2'b11, 2'b11, 0, 0, 1, 8'd1)); // B1 full -> drop
    vecs.push_back(mk(0, 9'h000, 0, 0, 0, 2'b11, 2'b11, 0, 0, 0, 8'd1)); // drop is one cycle
    vecs.push_back(mk(1, 9'h070, 1, 0, 0, 2'b11, 2'b11, 0, 0, 0, 8'd1)); // unrelated code
    vecs.push_back(mk(1, 9'h069, 0, 0, 0, 2'b11, 2'b11, 0, 0, 0, 8'd1)); // B1 break
    vecs.push_back(mk(0, 9'h000, 0, 1, 0, 2'b00, 2'b11, 0, 0, 0, 8'd1)); // board_b1 rises
    vecs.push_back(mk(0, 9'h000, 0, 1, 0, 2'b00, 2'b11, 0, 0, 0, 8'd1)); // held
    vecs.push_back(mk(1, 9'h069, 1, 1, 0, 2'b10, 2'b11, 1, 0, 0, 8'd1)); // press during hold
    vecs.push_back(mk(0, 9'h000, 0, 1, 0, 2'b10, 2'b11, 0, 0, 0, 8'd1)); // not cleared again
    vecs.push_back(mk(0, 9'h000, 0, 1, 0, 2'b10, 2'b11, 0, 0, 0, 8'd1));
    vecs.push_back(mk(1, 9'h072, 0, 0, 0, 2'b10, 2'b11, 0, 0, 0, 8'd1)); // B2 break
    vecs.push_back(mk(1, 9'h072, 1, 0, 1, 2'b10, 2'b10, 0, 1, 0, 8'd1)); // board+press B2
    vecs.push_back(mk(0, 9'h000, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 8'd1)); // board held
    vecs.push_back(mk(1, 9'h072, 1, 0, 0, 2'b10, 2'b10, 0, 0, 0, 8'd1)); // typematic ignored

    rst = 1'b1;
    drive(0, 9'h000, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk_all("reset", 2'b00, 2'b00, 0, 0, 0, 8'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].kv, vecs[i].code, vecs[i].down, vecs[i].b1, vecs[i].b2);
      chk_all($sformatf("v%0d", i), vecs[i].at1, vecs[i].at2, vecs[i].a1, vecs[i].a2,
              vecs[i].dr, vecs[i].cnt);
    end

    // Fill B1, then reject 300 presses; counter must saturate at 8'hFF.
    step(1, 9'h069, 0, 0, 0);
    step(1, 9'h069, 1, 0, 0);
    chk("fill.at_b1", 32'(at_b1), 32'h3);
    chk("fill.add_b1", 32'(add_b1), 32'h1);
    exp_cnt = 8'd1;
    for (int i = 0; i < 300; i++) begin
      step(1, 9'h069, 0, 0, 0);
      step(1, 9'h069, 1, 0, 0);
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      chk($sformatf("sat%0d.drop", i), 32'(drop), 32'h1);
      chk($sformatf("sat%0d.drop_cnt", i), 32'(drop_cnt), 32'(exp_cnt));
      chk($sformatf("sat%0d.at_b1", i), 32'(at_b1), 32'h3);
    end
    chk("sat.final_cnt", 32'(drop_cnt), 32'hFF);

    // One more rejected press, then reset between clock edges while drop is high.
    step(1, 9'h069, 0, 0, 0);
    step(1, 9'h069, 1, 0, 0);
    key_valid = 1'b0;
    chk("pre_rst.drop", 32'(drop), 32'h1);
    #1 rst = 1'b1;
    #1 chk_all("async_rst", 2'b00, 2'b00, 0, 0, 0, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Key 069 is still held; its next typematic make must count after reset.
    step(1, 9'h069, 1, 0, 0);
    chk_all("post_rst", 2'b10, 2'b00, 1, 0, 0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
